comparator_nmr: RTL and testbench

COMPARATOR_NMR -- requirements
Module: comparator_nmr

---
 rtl/comp_pkg.sv | 27 ++
 rtl/comp_voter.sv | 44 ++++
 rtl/comparator_nmr.sv | 195 +++++++++++++++++++
 tb/tb_comparator_nmr.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types and defaults for the NMR fingerprint comparator.
// State encoding, legal core counts and default widths.
package comp_pkg;

  localparam int CORES_DMR     = 2;
  localparam int CORES_TMR     = 3;
  localparam int DEF_NUM_TASKS = 16;
  localparam int DEF_CRC_WIDTH = 32;
  localparam int DEF_TIMEOUT   = 1024;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_SET_TASK      = 4'd1,
    S_LOAD0         = 4'd2,
    S_LOAD1         = 4'd3,
    S_CHECK_STATUS  = 4'd4,
    S_TASK_COMPLETE = 4'd5,
    S_COMPARE       = 4'd6,
    S_INCREMENT     = 4'd7,
    S_CHECK_DONE    = 4'd8,
    S_MISMATCH      = 4'd9,
    S_RESET_READY   = 4'd10,
    S_VERIFIED      = 4'd11,
    S_WRITE_STATUS  = 4'd12
  } state_e;

endpackage

// File: rtl/comp_voter.sv
// Combinational fingerprint voter for 2 (exact match) or 3 (majority)
// cores; reports the outvoted core when a majority masks a fault.
module comp_voter
  import comp_pkg::*;
#(
  parameter int NUM_CORES = CORES_DMR,
  parameter int CRC_WIDTH = DEF_CRC_WIDTH
) (
  input  logic [NUM_CORES*CRC_WIDTH-1:0] fprint,
  output logic                           pass,
  output logic [NUM_CORES-1:0]           faulty
);

  logic [CRC_WIDTH-1:0] f0, f1;

  assign f0 = fprint[0 +: CRC_WIDTH];
  assign f1 = fprint[CRC_WIDTH +: CRC_WIDTH];

  if (NUM_CORES == CORES_TMR) begin : g_tmr
    logic [CRC_WIDTH-1:0] f2;
    logic e01, e02, e12;

    assign f2  = fprint[2*CRC_WIDTH +: CRC_WIDTH];
    assign e01 = (f0 == f1);
    assign e02 = (f0 == f2);
    assign e12 = (f1 == f2);

    always_comb begin
      pass   = 1'b1;
      faulty = '0;
      priority case (1'b1)
        e01 && e12: pass = 1'b1;
        e01:        faulty = NUM_CORES'(3'b100);
        e02:        faulty = NUM_CORES'(3'b010);
        e12:        faulty = NUM_CORES'(3'b001);
        default:    pass = 1'b0;
      endcase
    end
  end else begin : g_dmr
    assign pass   = (f0 == f1);
    assign faulty = '0;
  end

endmodule

// File: rtl/comparator_nmr.sv
// Round-robin task scanner and fingerprint compare FSM for NMR cores.
// Define COMP_TIMEOUT_EN to add the handshake watchdog and comp_timeout.
module comparator_nmr
  import comp_pkg::*;
#(
  parameter int NUM_TASKS      = DEF_NUM_TASKS,
  parameter int NUM_CORES      = CORES_DMR,
  parameter int CRC_WIDTH      = DEF_CRC_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_TASKS-1:0]           fprints_ready,
  input  logic [NUM_TASKS-1:0]           checkin,
  input  logic [NUM_CORES*CRC_WIDTH-1:0] fprint,
  input  logic                           heads_match,
  input  logic [NUM_CORES-1:0]           tail_at_head,
  output logic [$clog2(NUM_TASKS)-1:0]   comp_task,
  output logic                           comp_reset_fprint_ready,
  input  logic                           reset_fprint_ack,
  output logic                           comp_task_verified,
  input  logic                           fprint_reg_ack,
  output logic                           comp_status_write,
  input  logic                           comp_status_ack,
  output logic                           comp_increment_tail_pointer,
  output logic                           comp_mismatch_detected,
  output logic [NUM_CORES-1:0]           comp_faulty_core,
  output logic                           comp_busy
`ifdef COMP_TIMEOUT_EN
  ,
  output logic                           comp_timeout
`endif
);

  localparam int TW = $clog2(NUM_TASKS);

  state_e               state_q, state_d, state_nxt;
  logic [TW-1:0]        task_q, task_d;
  logic [TW-1:0]        last_q, last_d;
  logic [TW-1:0]        pick_q, pick_d;
  logic                 mm_q, mm_d;
  logic [NUM_CORES-1:0] faulty_q, faulty_d;

  logic [NUM_TASKS-1:0] req;
  logic [TW-1:0]        scan_idx, pick_idx;
  logic                 pick_found;
  logic                 task_done;
  logic                 vote_pass;
  logic [NUM_CORES-1:0] vote_faulty;

  assign req       = fprints_ready | checkin;
  assign task_done = checkin[task_q];

  comp_voter #(
    .NUM_CORES (NUM_CORES),
    .CRC_WIDTH (CRC_WIDTH)
  ) u_voter (
    .fprint (fprint),
    .pass   (vote_pass),
    .faulty (vote_faulty)
  );

  // Walk downward so the last hit is the first index after last_q.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      scan_idx = TW'((int'(last_q) + i + 1) % NUM_TASKS);
      if (req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    task_d    = task_q;
    last_d    = last_q;
    pick_d    = pick_q;
    mm_d      = mm_q;
    faulty_d  = faulty_q;
    unique case (state_q)
      S_IDLE: begin
        task_d   = '0;
        mm_d     = 1'b0;
        faulty_d = '0;
        if (pick_found) begin
          pick_d    = pick_idx;
          state_nxt = S_SET_TASK;
        end
      end
      S_SET_TASK: begin
        task_d    = pick_q;
        last_d    = pick_q;
        state_nxt = S_LOAD0;
      end
      S_LOAD0:        state_nxt = S_LOAD1;
      S_LOAD1:        state_nxt = S_CHECK_STATUS;
      S_CHECK_STATUS:
        state_nxt = task_done ? S_TASK_COMPLETE : S_COMPARE;
      S_TASK_COMPLETE: begin
        if (!heads_match)       state_nxt = S_MISMATCH;
        else if (&tail_at_head) state_nxt = S_VERIFIED;
        else                    state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        faulty_d  = faulty_q | vote_faulty;
        state_nxt = vote_pass ? S_INCREMENT : S_MISMATCH;
      end
      S_INCREMENT:    state_nxt = S_CHECK_DONE;
      S_CHECK_DONE:
        state_nxt = (|tail_at_head) ? S_RESET_READY : S_COMPARE;
      S_MISMATCH: begin
        mm_d      = 1'b1;
        state_nxt = S_RESET_READY;
      end
      S_RESET_READY: begin
        if (reset_fprint_ack)
          state_nxt = (task_done || mm_q) ? S_VERIFIED : S_IDLE;
      end
      S_VERIFIED:
        if (fprint_reg_ack) state_nxt = S_WRITE_STATUS;
      S_WRITE_STATUS:
        if (comp_status_ack) state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

`ifdef COMP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;
  logic          waiting, stay, tmo_hit;

  assign waiting = (state_q == S_RESET_READY) ||
                   (state_q == S_VERIFIED) ||
                   (state_q == S_WRITE_STATUS);
  // Wait states only move on their ack, so "stay" means no ack yet.
  assign stay    = waiting && (state_nxt == state_q);
  assign tmo_hit = stay && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_d     = tmo_hit;
    tmo_cnt_d = '0;
    state_d   = tmo_hit ? S_IDLE : state_nxt;
    if (stay && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign comp_timeout = tmo_q;
`else
  assign state_d = state_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      task_q   <= '0;
      last_q   <= TW'(NUM_TASKS - 1);
      pick_q   <= '0;
      mm_q     <= 1'b0;
      faulty_q <= '0;
    end else begin
      state_q  <= state_d;
      task_q   <= task_d;
      last_q   <= last_d;
      pick_q   <= pick_d;
      mm_q     <= mm_d;
      faulty_q <= faulty_d;
    end
  end

  assign comp_task                   = task_q;
  assign comp_reset_fprint_ready     = (state_q == S_RESET_READY);
  assign comp_task_verified          = (state_q == S_VERIFIED);
  assign comp_status_write           = (state_q == S_WRITE_STATUS);
  assign comp_increment_tail_pointer = (state_q == S_INCREMENT);
  assign comp_mismatch_detected      = mm_q;
  assign comp_faulty_core            = faulty_q;
  assign comp_busy                   = (state_q != S_IDLE);

endmodule

// File: tb/tb_comparator_nmr.sv
// Directed bench for comparator_nmr: a 2-core and a 3-core instance.
// Watchdog scenario runs only when COMP_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_comparator_nmr;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] a_ready, a_checkin;
  logic [63:0] a_fprint;
  logic        a_heads;
  logic [1:0]  a_tah;
  logic        a_rst_ack, a_reg_ack, a_st_ack;
  logic [3:0]  a_task;
  logic        a_rrdy, a_ver, a_sw, a_inc, a_mm, a_busy;
  logic [1:0]  a_faulty;

  logic [15:0] b_ready, b_checkin;
  logic [95:0] b_fprint;
  logic        b_heads;
  logic [2:0]  b_tah;
  logic        b_rst_ack, b_reg_ack, b_st_ack;
  logic [3:0]  b_task;
  logic        b_rrdy, b_ver, b_sw, b_inc, b_mm, b_busy;
  logic [2:0]  b_faulty;
`ifdef COMP_TIMEOUT_EN
  logic        a_tmo, b_tmo;
`endif

  comparator_nmr #(
    .NUM_TASKS (16), .NUM_CORES (2), .CRC_WIDTH (32), .TIMEOUT_CYCLES (8)
  ) dut_a (
    .clk (clk), .reset_n (reset_n),
    .fprints_ready (a_ready), .checkin (a_checkin), .fprint (a_fprint),
    .heads_match (a_heads), .tail_at_head (a_tah), .comp_task (a_task),
    .comp_reset_fprint_ready (a_rrdy), .reset_fprint_ack (a_rst_ack),
    .comp_task_verified (a_ver), .fprint_reg_ack (a_reg_ack),
    .comp_status_write (a_sw), .comp_status_ack (a_st_ack),
    .comp_increment_tail_pointer (a_inc),
    .comp_mismatch_detected (a_mm), .comp_faulty_core (a_faulty),
    .comp_busy (a_busy)
`ifdef COMP_TIMEOUT_EN
    , .comp_timeout (a_tmo)
`endif
  );

  comparator_nmr #(
    .NUM_TASKS (16), .NUM_CORES (3), .CRC_WIDTH (32), .TIMEOUT_CYCLES (8)
  ) dut_b (
    .clk (clk), .reset_n (reset_n),
    .fprints_ready (b_ready), .checkin (b_checkin), .fprint (b_fprint),
    .heads_match (b_heads), .tail_at_head (b_tah), .comp_task (b_task),
    .comp_reset_fprint_ready (b_rrdy), .reset_fprint_ack (b_rst_ack),
    .comp_task_verified (b_ver), .fprint_reg_ack (b_reg_ack),
    .comp_status_write (b_sw), .comp_status_ack (b_st_ack),
    .comp_increment_tail_pointer (b_inc),
    .comp_mismatch_detected (b_mm), .comp_faulty_core (b_faulty),
    .comp_busy (b_busy)
`ifdef COMP_TIMEOUT_EN
    , .comp_timeout (b_tmo)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_ready = 16'h0001;
    b_ready = 16'h0001;
    tick();
    tick();
    checks++;
    if ({a_task, a_rrdy, a_ver, a_sw, a_inc, a_mm, a_faulty, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want 0",
               {a_task, a_rrdy, a_ver, a_sw, a_inc, a_mm, a_faulty, a_busy});
    end
    checks++;
    if ({b_task, b_rrdy, b_ver, b_sw, b_inc, b_mm, b_faulty, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_b got %h want 0",
               {b_task, b_rrdy, b_ver, b_sw, b_inc, b_mm, b_faulty, b_busy});
    end
`ifdef COMP_TIMEOUT_EN
    checks++;
    if (a_tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_tmo got %b want 0", a_tmo);
    end
`endif
    a_ready = '0;
    b_ready = '0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int got[3];
    int n = 0;
    int exp_rr[3] = '{0, 2, 0};
    a_fprint  = {2{32'h1234_5678}};
    a_tah     = 2'b11;
    a_rst_ack = 1'b1;
    a_ready   = 16'h0005;
    for (int c = 0; c < 60 && n < 3; c++) begin
      tick();
      if (a_inc) begin
        got[n] = int'(a_task);
        n++;
      end
    end
    a_ready = '0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL rr_loops got %0d want 3", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] != exp_rr[k]) begin
        errors++;
        $display("FAIL rr_task%0d got %0d want %0d", k, got[k], exp_rr[k]);
      end
    end
    for (int c = 0; c < 30 && a_busy; c++) tick();
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_2core_match();
    int inc_n = 0;
    int rrdy_n = 0;
    int ver_n = 0;
    logic mm_any = 1'b0;
    a_fprint  = {2{32'hA5A5_A5A5}};
    a_tah     = 2'b11;
    a_rst_ack = 1'b1;
    a_ready   = 16'h0010;
    tick();
    a_ready = 16'h0020;
    tick();
    a_ready = '0;
    checks++;
    if (a_task !== 4'd4) begin
      errors++;
      $display("FAIL match_task got %0d want 4", a_task);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      inc_n  += int'(a_inc);
      rrdy_n += int'(a_rrdy);
      ver_n  += int'(a_ver);
      mm_any |= a_mm;
      if (!a_busy) break;
    end
    checks++;
    if (inc_n != 1) begin
      errors++;
      $display("FAIL match_inc got %0d want 1", inc_n);
    end
    checks++;
    if (rrdy_n != 1 || ver_n != 0) begin
      errors++;
      $display("FAIL match_hs got rrdy=%0d ver=%0d want 1 0", rrdy_n, ver_n);
    end
    checks++;
    if (mm_any !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL match_end got mm=%b busy=%b want 0 0", mm_any, a_busy);
    end
  endtask

  task automatic test_checkin_mismatch();
    int t_r = -1;
    int t_v = -1;
    int t_s = -1;
    int inc_n = 0;
    logic mm_at_v = 1'b0;
    a_heads   = 1'b0;
    a_tah     = 2'b11;
    a_rst_ack = 1'b1;
    a_reg_ack = 1'b1;
    a_st_ack  = 1'b1;
    a_checkin = 16'h0100;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (a_rrdy && t_r < 0) t_r = c;
      if (a_ver && t_v < 0) begin
        t_v = c;
        mm_at_v = a_mm;
        a_checkin = '0;
      end
      if (a_sw && t_s < 0) t_s = c;
      inc_n += int'(a_inc);
      if (!a_busy) break;
    end
    a_checkin = '0;
    checks++;
    if (t_r != 6 || t_v != 7 || t_s != 8) begin
      errors++;
      $display("FAIL ci_seq got %0d/%0d/%0d want 6/7/8", t_r, t_v, t_s);
    end
    checks++;
    if (mm_at_v !== 1'b1) begin
      errors++;
      $display("FAIL ci_mm got %b want 1", mm_at_v);
    end
    checks++;
    if (inc_n != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ci_end got inc=%0d busy=%b want 0 0", inc_n, a_busy);
    end
    tick();
    checks++;
    if (a_mm !== 1'b0) begin
      errors++;
      $display("FAIL ci_mm_clr got %b want 0", a_mm);
    end
    a_heads   = 1'b1;
    a_reg_ack = 1'b0;
    a_st_ack  = 1'b0;
  endtask

  task automatic test_tmr_masked();
    int inc_n = 0;
    int ver_n = 0;
    logic [2:0] f_at_r = 3'b000;
    logic mm_any = 1'b0;
    b_fprint  = {32'h0BAD_0BAD, 32'hCAFE_F00D, 32'hCAFE_F00D};
    b_tah     = 3'b111;
    b_heads   = 1'b1;
    b_rst_ack = 1'b1;
    b_ready   = 16'h0002;
    tick();
    b_ready = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      inc_n += int'(b_inc);
      ver_n += int'(b_ver);
      mm_any |= b_mm;
      if (b_rrdy) f_at_r = b_faulty;
      if (!b_busy) break;
    end
    checks++;
    if (f_at_r !== 3'b100) begin
      errors++;
      $display("FAIL tmr_faulty got %b want 100", f_at_r);
    end
    checks++;
    if (inc_n != 1 || ver_n != 0 || mm_any !== 1'b0) begin
      errors++;
      $display("FAIL tmr_pass got inc=%0d ver=%0d mm=%b want 1 0 0",
               inc_n, ver_n, mm_any);
    end
    tick();
    checks++;
    if (b_faulty !== 3'b000 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL tmr_clr got faulty=%b busy=%b want 000 0", b_faulty, b_busy);
    end
  endtask

  task automatic test_tmr_disagree();
    b_fprint  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    b_rst_ack = 1'b0;
    b_reg_ack = 1'b0;
    b_st_ack  = 1'b0;
    b_ready   = 16'h0004;
    tick();
    b_ready = '0;
    for (int c = 0; c < 20 && !b_rrdy; c++) tick();
    checks++;
    if (b_rrdy !== 1'b1 || b_mm !== 1'b1 || b_faulty !== 3'b000) begin
      errors++;
      $display("FAIL dis_mm got rrdy=%b mm=%b faulty=%b want 1 1 000",
               b_rrdy, b_mm, b_faulty);
    end
    b_reg_ack = 1'b1;
    b_st_ack  = 1'b1;
    tick();
    tick();
    checks++;
    if (b_rrdy !== 1'b1 || b_ver !== 1'b0 || b_sw !== 1'b0) begin
      errors++;
      $display("FAIL dis_hold got rrdy=%b ver=%b sw=%b want 1 0 0",
               b_rrdy, b_ver, b_sw);
    end
    b_reg_ack = 1'b0;
    b_st_ack  = 1'b0;
    b_rst_ack = 1'b1;
    tick();
    b_rst_ack = 1'b0;
    checks++;
    if (b_ver !== 1'b1 || b_rrdy !== 1'b0) begin
      errors++;
      $display("FAIL dis_ver got ver=%b rrdy=%b want 1 0", b_ver, b_rrdy);
    end
    tick();
    tick();
    checks++;
    if (b_ver !== 1'b1) begin
      errors++;
      $display("FAIL dis_ver_hold got %b want 1", b_ver);
    end
    b_reg_ack = 1'b1;
    tick();
    b_reg_ack = 1'b0;
    checks++;
    if (b_sw !== 1'b1 || b_ver !== 1'b0) begin
      errors++;
      $display("FAIL dis_sw got sw=%b ver=%b want 1 0", b_sw, b_ver);
    end
    b_st_ack = 1'b1;
    tick();
    b_st_ack = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_sw !== 1'b0) begin
      errors++;
      $display("FAIL dis_idle got busy=%b sw=%b want 0 0", b_busy, b_sw);
    end
    tick();
    checks++;
    if (b_mm !== 1'b0) begin
      errors++;
      $display("FAIL dis_mm_clr got %b want 0", b_mm);
    end
  endtask

  task automatic test_midreset();
    b_fprint  = {3{32'h5555_AAAA}};
    b_tah     = 3'b111;
    b_rst_ack = 1'b0;
    b_ready   = 16'h0008;
    tick();
    b_ready = '0;
    for (int c = 0; c < 20 && !b_rrdy; c++) tick();
    checks++;
    if (b_rrdy !== 1'b1) begin
      errors++;
      $display("FAIL mr_reach got rrdy=%b want 1", b_rrdy);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({b_task, b_rrdy, b_ver, b_sw, b_inc, b_mm, b_faulty, b_busy} !== '0) begin
      errors++;
      $display("FAIL mr_reset got %h want 0",
               {b_task, b_rrdy, b_ver, b_sw, b_inc, b_mm, b_faulty, b_busy});
    end
    reset_n = 1'b1;
    b_rst_ack = 1'b1;
    tick();
    tick();
    checks++;
    if (b_busy !== 1'b0 || b_rrdy !== 1'b0 || b_ver !== 1'b0) begin
      errors++;
      $display("FAIL mr_abandon got busy=%b rrdy=%b ver=%b want 0 0 0",
               b_busy, b_rrdy, b_ver);
    end
  endtask

`ifdef COMP_TIMEOUT_EN
  task automatic test_timeout();
    a_heads   = 1'b1;
    a_tah     = 2'b11;
    a_reg_ack = 1'b0;
    a_checkin = 16'h0001;
    for (int c = 0; c < 20 && !a_ver; c++) tick();
    a_checkin = '0;
    checks++;
    if (a_ver !== 1'b1) begin
      errors++;
      $display("FAIL to_reach got ver=%b want 1", a_ver);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        checks++;
        if (a_tmo !== 1'b0 || a_ver !== 1'b1) begin
          errors++;
          $display("FAIL to_wait%0d got tmo=%b ver=%b want 0 1", k, a_tmo, a_ver);
        end
      end else begin
        checks++;
        if (a_tmo !== 1'b1 || a_busy !== 1'b0) begin
          errors++;
          $display("FAIL to_fire got tmo=%b busy=%b want 1 0", a_tmo, a_busy);
        end
      end
    end
    tick();
    checks++;
    if (a_tmo !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got %b want 0", a_tmo);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_ready = '0; a_checkin = '0; a_fprint = '0; a_heads = 1'b1; a_tah = '0;
    a_rst_ack = 1'b0; a_reg_ack = 1'b0; a_st_ack = 1'b0;
    b_ready = '0; b_checkin = '0; b_fprint = '0; b_heads = 1'b1; b_tah = '0;
    b_rst_ack = 1'b0; b_reg_ack = 1'b0; b_st_ack = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_round_robin();
    test_2core_match();
    test_checkin_mismatch();
    test_tmr_masked();
    test_tmr_disagree();
    test_midreset();
`ifdef COMP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
